// File: rtl/reg_file_wb_queue.sv
// Writeback queue in front of the register file's single write port.
// Requests are buffered in a circular FIFO and drained one per cycle unless
// the write port is stalled. Read ports are forwarded from pending entries so
// a read never sees a stale value for a register with an outstanding write.
module reg_file_wb_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [ADDR_WIDTH-1:0]     in_reg_i,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    input  logic                      wr_stall_i,
    output logic                      wr_en_o,
    output logic [ADDR_WIDTH-1:0]     wr_reg_o,
    output logic [DATA_WIDTH-1:0]     wr_data_o,
    input  logic [ADDR_WIDTH-1:0]     rd_reg_1_i,
    input  logic [ADDR_WIDTH-1:0]     rd_reg_2_i,
    input  logic [DATA_WIDTH-1:0]     rf_rd_data_1_i,
    input  logic [DATA_WIDTH-1:0]     rf_rd_data_2_i,
    output logic [DATA_WIDTH-1:0]     rd_data_1_o,
    output logic [DATA_WIDTH-1:0]     rd_data_2_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_WIDTH-1:0] reg_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PtrW-1:0]       head_q, tail_q;
    logic [CntW-1:0]       count_q, count_d;

    logic full, empty, accept, push, pop;

    // Handshake, drain and occupancy bookkeeping.
    always_comb begin
        full       = (count_q == CntW'(DEPTH));
        empty      = (count_q == '0);
        // Readiness depends only on registered occupancy: a full queue does
        // not accept even when it drains in the same cycle.
        in_ready_o = !full && !rst_i;
        accept     = in_valid_i && in_ready_o;
        // x0 writes are swallowed: the handshake completes but nothing is kept.
        push       = accept && (in_reg_i != '0);
        // Gating by reset keeps discarded entries off the write port.
        pop        = !empty && !wr_stall_i && !rst_i;
        wr_en_o    = pop;
        wr_reg_o   = reg_q[head_q];
        wr_data_o  = data_q[head_q];
        count_o    = count_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Read forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        rd_data_1_o = rf_rd_data_1_i;
        rd_data_2_o = rf_rd_data_2_i;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[head_q + PtrW'(i)] && (reg_q[head_q + PtrW'(i)] == rd_reg_1_i)) begin
                rd_data_1_o = data_q[head_q + PtrW'(i)];
            end
            if (valid_q[head_q + PtrW'(i)] && (reg_q[head_q + PtrW'(i)] == rd_reg_2_i)) begin
                rd_data_2_o = data_q[head_q + PtrW'(i)];
            end
        end
        if (rd_reg_1_i == '0) begin
            rd_data_1_o = '0;
        end
        if (rd_reg_2_i == '0) begin
            rd_data_2_o = '0;
        end
    end

    // Queue state: pointers, occupancy, entry valid bits and storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            // push and pop never target the same slot: that needs full or empty.
            if (push) begin
                reg_q[tail_q]   <= in_reg_i;
                data_q[tail_q]  <= in_data_i;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrW'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_file_wb_queue.sv
// Scoreboard bench for reg_file_wb_queue: the driver pushes every accepted
// non-x0 request into an expected queue; the monitor checks occupancy,
// readiness, forwarding and in-order writes against that queue each cycle.
module tb_reg_file_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, wr_stall, wr_en;
    logic [AW-1:0] in_reg, wr_reg, rd_reg_1, rd_reg_2;
    logic [DW-1:0] in_data, wr_data, rf_1, rf_2, rd_data_1, rd_data_2;
    logic [$clog2(DEPTH):0] count;

    ent_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   writes   = 0;

    always #5 clk = ~clk;

    reg_file_wb_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_reg_i       (in_reg),
        .in_data_i      (in_data),
        .wr_stall_i     (wr_stall),
        .wr_en_o        (wr_en),
        .wr_reg_o       (wr_reg),
        .wr_data_o      (wr_data),
        .rd_reg_1_i     (rd_reg_1),
        .rd_reg_2_i     (rd_reg_2),
        .rf_rd_data_1_i (rf_1),
        .rf_rd_data_2_i (rf_2),
        .rd_data_1_o    (rd_data_1),
        .rd_data_2_o    (rd_data_2),
        .count_o        (count)
    );

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference forwarding: x0 reads zero, else youngest pending write, else RF.
    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r, input logic [DW-1:0] rf);
        logic [DW-1:0] res;
        if (r == '0) return '0;
        res = rf;
        foreach (expq[i]) if (expq[i].r == r) res = expq[i].d;
        return res;
    endfunction

    // Monitor: compare every cycle away from the active edge.
    always @(negedge clk) begin
        chk("count", 64'(count), 64'(expq.size()));
        chk("in_ready", 64'(in_ready), 64'((expq.size() < DEPTH) && !rst));
        chk("rd_data_1", 64'(rd_data_1), 64'(fwd(rd_reg_1, rf_1)));
        chk("rd_data_2", 64'(rd_data_2), 64'(fwd(rd_reg_2, rf_2)));
        chk("wr_en", 64'(wr_en), 64'((expq.size() > 0) && !wr_stall && !rst));
        if (wr_en) begin
            if (expq.size() == 0) begin
                chk("wr_unexpected", 64'(wr_en), 64'(0));
            end else begin
                chk("wr_reg", 64'(wr_reg), 64'(expq[0].r));
                chk("wr_data", 64'(wr_data), 64'(expq[0].d));
                void'(expq.pop_front());
                writes++;
            end
        end
    end

    task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                         input logic s, input logic rs);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        wr_stall = s;
        rst      = rs;
    endtask

    // One cycle: note the handshake before the edge, update the model after it.
    task automatic step();
        logic acc, rs;
        @(negedge clk);
        acc = in_valid && in_ready;
        rs  = rst;
        @(posedge clk);
        if (rs) expq.delete();
        else if (acc && in_reg != '0) expq.push_back(ent_t'({in_reg, in_data}));
        #1;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        rd_reg_1 = '0; rd_reg_2 = '0; rf_1 = 32'hFFFF_FFFF; rf_2 = '0;
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        step();

        // Single push drains on the following cycle.
        rd_reg_1 = 5; rf_1 = 32'h1;
        drive(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        step();

        // Fill under stall, attempt a fifth push, then drain in order.
        rd_reg_1 = 3; rd_reg_2 = 4;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, AW'(i), DW'(i * 32'h11), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step();

        // Duplicate destination: youngest forwarded, both written in order.
        rd_reg_2 = 7; rf_2 = '0;
        drive(1'b1, 7, 32'hA, 1'b1, 1'b0);
        step();
        drive(1'b1, 7, 32'hB, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // x0 request: handshake completes, nothing stored.
        drive(1'b1, 0, 32'h1234, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        step();

        // Reset with three entries pending under stall.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(9 + i), DW'(32'h900 + i), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic with collisions on a small register set.
        for (int n = 0; n < 600; n++) begin
            rd_reg_1 = AW'($urandom_range(0, 7));
            rd_reg_2 = AW'($urandom_range(0, 7));
            rf_1     = $urandom;
            rf_2     = $urandom;
            if ($urandom_range(0, 99) < 3) begin
                drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom, 1'b1, 1'b1);
            end else begin
                drive(1'($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 99) < 30), 1'b0);
            end
            step();
        end

        // Drain with a bounded wait.
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && expq.size() > 0; i++) step();
        chk("drain_empty", 64'(expq.size()), 64'(0));
        step();
        chk("writes_seen", 64'(writes > 0), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
